// File: rtl/beta_pkg.sv
// Shared types for the Beta pipeline hazard/bypass controller: bypass selects,
// scoreboard entry layout and the hard-wired zero register.
package beta_pkg;

   typedef enum logic [1:0] {
      BYP_RF  = 2'd0,
      BYP_EX  = 2'd1,
      BYP_MEM = 2'd2,
      BYP_WB  = 2'd3
   } byp_sel_t;

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [4:0] rc;
      logic       is_load;
   } sb_entry_t;

   localparam logic [4:0] REG_ZERO = 5'd31;

   // R31 reads as zero, so a write to it never produces a dependency.
   function automatic logic writes_reg(input sb_entry_t e, input logic [4:0] r);
      return e.valid & e.we & (e.rc == r) & (r != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One source operand against the EX/MEM/WB scoreboard: bypass select plus hazard flag.
// PIPE_CTRL_BYPASS_EN enables bypassing; without it any in-flight writer is a hazard.
module hazard_cmp
   import beta_pkg::*;
(
   input  logic [4:0] ra_i,
   input  logic       use_i,
   input  sb_entry_t  ex_i,
   input  sb_entry_t  mem_i,
   input  sb_entry_t  wb_i,
   output byp_sel_t   byp_sel_o,
   output logic       hz_o
);

   logic hit_ex, hit_mem, hit_wb;

   assign hit_ex  = use_i & writes_reg(ex_i, ra_i);
   assign hit_mem = use_i & writes_reg(mem_i, ra_i);
   assign hit_wb  = use_i & writes_reg(wb_i, ra_i);

`ifdef PIPE_CTRL_BYPASS_EN
   // A load in WB already has its data on the writeback bus.
   logic unused_wb_ld;
   assign unused_wb_ld = wb_i.is_load;

   always_comb begin
      byp_sel_o = BYP_RF;
      hz_o      = 1'b0;
      if (hit_ex) begin
         byp_sel_o = BYP_EX;
         hz_o      = ex_i.is_load;
      end else if (hit_mem) begin
         byp_sel_o = BYP_MEM;
         hz_o      = mem_i.is_load;
      end else if (hit_wb) begin
         byp_sel_o = BYP_WB;
      end
   end
`else
   logic unused_ld;
   assign unused_ld = ex_i.is_load ^ mem_i.is_load ^ wb_i.is_load;

   assign byp_sel_o = BYP_RF;
   assign hz_o      = hit_ex | hit_mem | hit_wb;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Beta 5-stage hazard/bypass controller: registered EX/MEM/WB scoreboard, combinational
// selects, load-use interlock, bubble and annul; bypassing enabled by PIPE_CTRL_BYPASS_EN.
module pipe_ctrl
   import beta_pkg::*;
#(
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   dec_valid,
   input  logic [4:0]             dec_ra1,
   input  logic [4:0]             dec_ra2,
   input  logic                   dec_use_ra1,
   input  logic                   dec_use_ra2,
   input  logic [4:0]             dec_rc,
   input  logic                   dec_we,
   input  logic                   dec_is_load,
   input  logic                   dec_br_taken,
   input  logic                   ext_stall,
   output logic                   stall_f,
   output logic                   annul_f,
   output logic                   bubble_ex,
   output logic [1:0]             byp_sel_a,
   output logic [1:0]             byp_sel_b,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   sb_entry_t              ex_q, mem_q, wb_q;
   sb_entry_t              ex_d, mem_d, wb_d;
   logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
   byp_sel_t               sel_a, sel_b;
   logic                   hz_a, hz_b, hz;

   hazard_cmp u_cmp_a (
      .ra_i      (dec_ra1),
      .use_i     (dec_use_ra1),
      .ex_i      (ex_q),
      .mem_i     (mem_q),
      .wb_i      (wb_q),
      .byp_sel_o (sel_a),
      .hz_o      (hz_a)
   );

   hazard_cmp u_cmp_b (
      .ra_i      (dec_ra2),
      .use_i     (dec_use_ra2),
      .ex_i      (ex_q),
      .mem_i     (mem_q),
      .wb_i      (wb_q),
      .byp_sel_o (sel_b),
      .hz_o      (hz_b)
   );

   assign hz        = hz_a | hz_b;
   assign stall_f   = ext_stall | (dec_valid & hz);
   assign bubble_ex = dec_valid & hz & ~ext_stall;
   // A stalled branch may still be reading stale operands, so never annul under stall.
   assign annul_f   = dec_valid & dec_br_taken & ~stall_f;
   assign byp_sel_a = sel_a;
   assign byp_sel_b = sel_b;
   assign stall_cnt = cnt_q;

   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      cnt_d = cnt_q;
      if (!ext_stall) begin
         wb_d  = mem_q;
         mem_d = ex_q;
         if (hz) begin
            ex_d = '0;
         end else begin
            ex_d.valid   = dec_valid;
            ex_d.we      = dec_we;
            ex_d.rc      = dec_rc;
            ex_d.is_load = dec_is_load;
         end
      end
      if (bubble_ex && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline hazard and bypass controller for the 5-stage Beta pipeline (IF, RF, ALU, MEM, WB). It keeps a registered scoreboard of the destination register for each instruction downstream of decode, and from it generates the decode-stage bypass mux selects, load-use interlock stalls, ALU-stage bubble injection and fetch annulment on taken branches/jumps. It sits beside `decode` and drives its `stall` input and the `ex_bypass`/`mem_bypass`/`wb_bypass` mux selects.

## Interface
- `STALL_CNT_W`, 16: width of the saturating hazard-stall counter.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  asynchronous, active-high reset.
- `dec_valid`  in  1  RF stage holds a real (non-annulled) instruction.
- `dec_ra1`, `dec_ra2`  in  5  source register addresses read by decode.
- `dec_use_ra1`, `dec_use_ra2`  in  1  instruction actually consumes that operand.
- `dec_rc`  in  5  destination register of the decode instruction.
- `dec_we`  in  1  decode instruction writes `dec_rc`.
- `dec_is_load`  in  1  decode instruction is LD or LDR.
- `dec_br_taken`  in  1  decode resolved a taken BEQ/BNE/JMP this cycle.
- `ext_stall`  in  1  memory not ready; freeze whole pipeline.
- `stall_f`  out  1  hold PC and RF-stage IR.
- `annul_f`  out  1  load NOP into RF-stage IR at next edge.
- `bubble_ex`  out  1  load NOP into ALU stage at next edge.
- `byp_sel_a`, `byp_sel_b`  out  2  operand source: RF / EX / MEM / WB.
- `stall_cnt`  out  `STALL_CNT_W`  count of hazard-stall cycles, saturating.

## Operation
- Scoreboard: three entries EX, MEM, WB, each {valid, we, rc, is_load}. Entry "writes r" iff valid & we & rc == r & r != 31.
- Bypass select per operand (decode ra1 → a, ra2 → b): youngest match wins, EX > MEM > WB; no match or register 31 → RF. Unused operand → RF, never causes a stall.
- Load-use hazard: the youngest matching entry is a load in EX or MEM → `hz` = 1 (load data only exists at WB). A load matching in WB bypasses normally.
- `stall_f` = `ext_stall` | (`dec_valid` & `hz`).
- `bubble_ex` = `dec_valid` & `hz` & ~`ext_stall`.
- `annul_f` = `dec_valid` & `dec_br_taken` & ~`stall_f`. A branch under stall is re-evaluated next cycle with correct operands; it is never annulled early.
- Scoreboard update on posedge clk:
  - `ext_stall`: all entries hold.
  - Else `hz`: EX ← invalid (bubble), MEM ← EX, WB ← MEM.
  - Else EX ← {`dec_valid`, `dec_we`, `dec_rc`, `dec_is_load`}, MEM ← EX, WB ← MEM.
- `stall_cnt` increments on each cycle with `bubble_ex` = 1; holds at all-ones; `ext_stall` cycles are not counted.

## Timing
- All outputs combinational from decode inputs and the registered scoreboard; zero-cycle latency, no output registers.
- Reset: all scoreboard entries invalid, `stall_cnt` = 0; consequently `stall_f` = `annul_f` = `bubble_ex` = 0 and both selects = RF while decode inputs are idle.
- Load followed immediately by a dependent instruction: 2 stall cycles (load in EX, then MEM), then WB bypass. One independent instruction in between: 1 stall cycle.
- Simultaneous `ext_stall` and hazard: `ext_stall` dominates; no bubble, no count, scoreboard frozen.
- Reset asserted mid-stall: scoreboard cleared immediately; the stall drops in the same cycle.

## Configuration
- `PIPE_CTRL_BYPASS_EN` defined: full bypass behaviour as above.
- Undefined: both selects fixed at RF. `hz` = 1 for any match in EX, MEM or WB, regardless of `is_load`, so the instruction stalls until the writer has left WB. Scoreboard, annul and counter logic are unchanged.

## Structure
- `beta_pkg`: `byp_sel_t` enum (`BYP_RF`=0, `BYP_EX`=1, `BYP_MEM`=2, `BYP_WB`=3), `sb_entry_t` struct, constant `REG_ZERO` = 5'd31.
- Sub-module `hazard_cmp`: one source address plus three scoreboard entries → {`byp_sel`, `hz`}. Instantiated twice (operands a and b); `hz` = OR of both instances.

## Test plan
- After reset, ADD R1←R2,R3 then SUB R4←R1,R5 back-to-back → `byp_sel_a` = EX, no stall; the next instruction reading R1 gets MEM, the one after gets WB.
- LD R1 followed by ADD reading R1 → `stall_f` and `bubble_ex` high for 2 cycles, then `byp_sel_a` = WB; `stall_cnt` = 2.
- Instruction writing R31, then a reader of R31 → `byp_sel` = RF, no stall.
- BEQ taken with no hazard → `annul_f` = 1 for one cycle. BEQ dependent on an in-flight load → `annul_f` = 0 during both stall cycles, then 1.
- `ext_stall` held 3 cycles during a load-use hazard → scoreboard frozen, `bubble_ex` = 0, `stall_cnt` unchanged; the hazard resumes afterwards.
- Build without `PIPE_CTRL_BYPASS_EN`: ADD R1 then a reader of R1 → 3 stall cycles and selects always RF. Separately, drive 65540 hazard cycles → `stall_cnt` = 16'hFFFF.
